prog_counter_fetch: RTL and testbench
=====================================

// Module: prog_counter_fetch
// PURPOSE
//  Fetch/sequencing stage that sits directly upstream of the control decoder.
//  Holds the program counter and drives the instruction ROM address; instr[8:4] is the decoder opcode.
//  Resolves beq/bne using a condition flag latched from eq/lt results.
//  Runs a start/done handshake with the testbench and counts executed cycles.
// PARAMETERS
//  PC_W      10      program counter width (ROM depth 2**PC_W)
//  LAST_ADDR 1023    address of the final instruction; stepping past it halts
//  LUT_W     4       branch-target LUT index width, taken from instr[LUT_W-1:0]
//  CNT_W     16      cycle counter width
// PORTS
//  Clk         in   1      clock, rising edge
//  Reset       in   1      asynchronous, active-high reset
//  Start       in   1      pulse: begin or restart program execution
//  instr       in   9      instruction at address pc (ROM read is combinational)
//  cond_in     in   1      ALU eq/lt result for the current instruction
//  lut_target  in   PC_W   absolute branch target returned by the external LUT for lut_idx
//  pc          out  PC_W   current instruction address
//  lut_idx     out  LUT_W  instr[LUT_W-1:0], combinational
//  running     out  1      high in RUN state
//  Done        out  1      high in HALT state; held until next Start or Reset
//  cycle_cnt   out  CNT_W  number of RUN cycles since last Start; saturates at all-ones
// BEHAVIOUR
//  - Reset (async): state=IDLE, pc=0, cond_flag=0, cycle_cnt=0, running=0, Done=0.
//  - State machine:
//    - IDLE -> RUN on Start.
//    - RUN -> HALT when the sequential next address would exceed LAST_ADDR, or a taken
//      branch targets an address > LAST_ADDR.
//    - HALT -> RUN on Start. HALT otherwise holds pc and cycle_cnt.
//  - Start in any state, including RUN: next cycle pc=0, cond_flag=0, cycle_cnt=0, state=RUN.
//    Start takes priority over every other update.
//  - In RUN, one instruction retires per cycle. opcode = instr[8:4].
//  - Condition flag:
//    - opcode 01101 (eq) or 01110 (lt): cond_flag <= cond_in at the clock edge.
//    - All other opcodes leave cond_flag unchanged.
//  - Branches:
//    - opcode 00101 (beq) is taken iff cond_flag==1.
//    - opcode 00110 (bne) is taken iff cond_flag==0.
//    - Both use the flag value held before this cycle's edge.
//  - Next pc:
//    - Taken branch: pc <= lut_target.
//    - Otherwise: pc <= pc+1.
//    - No delay slot; the branch costs exactly one cycle.
//  - Halt condition: pc==LAST_ADDR with no taken branch -> HALT, and pc stays at LAST_ADDR.
//    pc never wraps to 0.
//  - cycle_cnt increments on every RUN cycle, including the halting cycle; it never wraps.
//  - Outputs are registered state except lut_idx.
//    - running = (state==RUN).
//    - Done = (state==HALT).
//  - In IDLE and HALT, instr and cond_in are ignored and cond_flag is frozen.
//  - Reset asserted mid-RUN aborts immediately to the reset values; no Done is produced.
// TESTING
//  - Reset, then Start at cycle 0 with NOPs (add) -> pc = 0,1,2,3 on successive cycles; running=1, Done=0.
//  - LAST_ADDR=5, straight-line code -> pc reaches 5, next cycle Done=1, pc holds 5, cycle_cnt=6.
//  - eq with cond_in=1, then beq, lut_target=40 -> pc=40 the cycle after the beq;
//    the same sequence with bne -> pc=beq_addr+1.
//  - lt with cond_in=0, then bne, lut_target=7 -> pc=7; check lut_idx equals instr[3:0] during the bne.
//  - Start pulsed mid-RUN at pc=12 -> next cycle pc=0, cycle_cnt=0, cond_flag=0.
//  - Reset asserted asynchronously mid-RUN -> pc=0 and running=0 before the next edge;
//    CNT_W=4 run of 20 cycles -> cycle_cnt saturates at 15.

Source files
------------

// File: rtl/prog_counter_fetch.sv
// prog_counter_fetch
//   Fetch/sequencing stage ahead of the control decoder. Holds the program
//   counter that addresses the instruction ROM. It resolves beq/bne from a
//   condition flag that eq/lt instructions latch. It also runs the Start/Done
//   handshake and counts the cycles spent in RUN.
//
// Ports
//   Clk         in   1      clock, rising edge
//   Reset       in   1      asynchronous, active-high reset
//   Start       in   1      pulse: begin or restart program execution
//   instr       in   9      instruction at address pc (combinational ROM)
//   cond_in     in   1      ALU eq/lt result for the current instruction
//   lut_target  in   PC_W   absolute branch target for lut_idx
//   pc          out  PC_W   current instruction address
//   lut_idx     out  LUT_W  instr[LUT_W-1:0], combinational
//   running     out  1      high in RUN
//   Done        out  1      high in HALT, held until Start or Reset
//   cycle_cnt   out  CNT_W  RUN cycles since last Start, saturating
//
// States
//   S_IDLE | waiting for the first Start after reset
//   S_RUN  | one instruction retires per cycle
//   S_HALT | program stepped past LAST_ADDR; pc and cycle_cnt frozen

module prog_counter_fetch #(
    parameter int PC_W      = 10,
    parameter int LAST_ADDR = 1023,
    parameter int LUT_W     = 4,
    parameter int CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [8:0]       instr,
    input  logic             cond_in,
    input  logic [PC_W-1:0]  lut_target,
    output logic [PC_W-1:0]  pc,
    output logic [LUT_W-1:0] lut_idx,
    output logic             running,
    output logic             Done,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [4:0] OP_BEQ = 5'b00101;
    localparam logic [4:0] OP_BNE = 5'b00110;
    localparam logic [4:0] OP_EQ  = 5'b01101;
    localparam logic [4:0] OP_LT  = 5'b01110;

    localparam logic [PC_W-1:0]  LAST_PC = PC_W'(LAST_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              cond_flag_q, cond_flag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [4:0]        opcode;
    logic              taken;

    assign opcode = instr[8:4];

    // Branch decision uses the flag as it stood before this edge, so an eq
    // immediately followed by beq sees the eq result.
    assign taken = ((opcode == OP_BEQ) &&  cond_flag_q) ||
                   ((opcode == OP_BNE) && !cond_flag_q);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cond_flag_d = cond_flag_q;
        cnt_d       = cnt_q;

        if (Start) begin
            state_d     = S_RUN;
            pc_d        = '0;
            cond_flag_d = 1'b0;
            cnt_d       = '0;
        end else if (state_q == S_RUN) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if ((opcode == OP_EQ) || (opcode == OP_LT)) begin
                cond_flag_d = cond_in;
            end
            if (taken) begin
                // A branch that leaves the program space halts in place.
                if (lut_target > LAST_PC) begin
                    state_d = S_HALT;
                end else begin
                    pc_d = lut_target;
                end
            end else if (pc_q >= LAST_PC) begin
                // Compare before incrementing so pc can never wrap to 0.
                state_d = S_HALT;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            cond_flag_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cond_flag_q <= cond_flag_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign lut_idx   = instr[LUT_W-1:0];
    assign running   = (state_q == S_RUN);
    assign Done      = (state_q == S_HALT);
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_prog_counter_fetch.sv
module tb_prog_counter_fetch;

    localparam int PC_W      = 6;
    localparam int LAST_ADDR = 45;
    localparam int LUT_W     = 4;
    localparam int CNT_W     = 5;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_BEQ = 5'b00101;
    localparam logic [4:0] OP_BNE = 5'b00110;
    localparam logic [4:0] OP_EQ  = 5'b01101;
    localparam logic [4:0] OP_LT  = 5'b01110;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic [8:0]       instr;
    logic             cond_in;
    logic [PC_W-1:0]  lut_target;
    logic [PC_W-1:0]  pc;
    logic [LUT_W-1:0] lut_idx;
    logic             running;
    logic             Done;
    logic [CNT_W-1:0] cycle_cnt;

    prog_counter_fetch #(
        .PC_W(PC_W), .LAST_ADDR(LAST_ADDR), .LUT_W(LUT_W), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .instr(instr),
        .cond_in(cond_in), .lut_target(lut_target), .pc(pc),
        .lut_idx(lut_idx), .running(running), .Done(Done),
        .cycle_cnt(cycle_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int pc;
        int run;
        int done;
        int cnt;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [8:0]      rom [64];
    logic [PC_W-1:0] lut [16];

    int m_pc, m_st, m_flag, m_cnt;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents its outputs, compare them against
    // the oldest pending expectation.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc",        int'(pc),        e.pc);
            check("running",   int'(running),   e.run);
            check("Done",      int'(Done),      e.done);
            check("cycle_cnt", int'(cycle_cnt), e.cnt);
            check("lut_idx",   int'(lut_idx),   e.idx);
        end
    end

    // Reference model: one clock edge of the program sequencer.
    task automatic model_edge(input bit st, input bit cnd, input logic [8:0] ins);
        int op, tgt;
        bit tk;
        if (st) begin
            m_pc = 0; m_flag = 0; m_cnt = 0; m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            op  = int'(ins[8:4]);
            tgt = int'(lut[ins[3:0]]);
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            tk = (op == OP_BEQ && m_flag == 1) || (op == OP_BNE && m_flag == 0);
            if (op == OP_EQ || op == OP_LT) m_flag = cnd;
            if (tk) begin
                if (tgt > LAST_ADDR) m_st = M_HALT;
                else                 m_pc = tgt;
            end else if (m_pc == LAST_ADDR) begin
                m_st = M_HALT;
            end else begin
                m_pc = m_pc + 1;
            end
        end
    endtask

    // Called just after a rising edge: drive this cycle's inputs, queue the
    // expected outputs, advance to the next edge and update the model.
    task automatic step(input bit st, input bit cnd, input bit rst = 1'b0);
        logic [8:0] ins;
        if (rst) begin
            Reset = 1'b1;
            m_pc = 0; m_st = M_IDLE; m_flag = 0; m_cnt = 0;
        end else begin
            Reset = 1'b0;
        end
        ins        = rom[m_pc];
        Start      = st;
        cond_in    = cnd;
        instr      = ins;
        lut_target = lut[ins[3:0]];
        exp_q.push_back('{m_pc, (m_st == M_RUN) ? 1 : 0, (m_st == M_HALT) ? 1 : 0,
                          m_cnt, int'(ins[3:0])});
        @(posedge Clk);
        if (!rst) model_edge(st, cnd, ins);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = {OP_ADD, 4'(i)};
        for (int i = 0; i < 16; i++) lut[i] = '0;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; instr = '0; cond_in = 1'b0; lut_target = '0;
        m_pc = 0; m_st = M_IDLE; m_flag = 0; m_cnt = 0;
        clear_rom();
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Reset state, then straight-line code to the end of program space.
        step(0, 0);
        step(1, 0);
        repeat (50) step(0, 0);

        // eq(1) then beq -> taken to 40; same with bne -> falls through.
        clear_rom();
        rom[0] = {OP_EQ, 4'd0};
        rom[1] = {OP_BEQ, 4'd3};
        lut[3] = 6'd40;
        step(1, 0);
        step(0, 1);
        repeat (4) step(0, 0);
        rom[1] = {OP_BNE, 4'd3};
        step(1, 0);
        step(0, 1);
        repeat (4) step(0, 0);

        // lt(0) then bne -> taken to 7.
        rom[0] = {OP_LT, 4'd0};
        rom[1] = {OP_BNE, 4'd5};
        lut[5] = 6'd7;
        step(1, 1);
        step(0, 0);
        repeat (4) step(0, 1);

        // Restart at pc=12 clears the flag: beq at 0 must then fall through.
        clear_rom();
        rom[0]  = {OP_BEQ, 4'd2};
        rom[10] = {OP_EQ, 4'd1};
        lut[2]  = 6'd30;
        step(1, 1);
        while (m_pc != 12) step(0, 1);
        step(1, 1);
        repeat (4) step(0, 1);

        // Taken branch beyond the last address halts with pc held.
        clear_rom();
        rom[0] = {OP_EQ, 4'd0};
        rom[1] = {OP_BEQ, 4'd9};
        lut[9] = 6'd50;
        step(1, 0);
        step(0, 1);
        repeat (4) step(0, 0);

        // Asynchronous reset in mid-run, then idle until the next Start.
        clear_rom();
        step(1, 0);
        repeat (6) step(0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        repeat (3) step(0, 0);

        // Random programs with occasional restarts.
        for (int i = 0; i < 64; i++) begin
            logic [4:0] ops [5];
            ops[0] = OP_ADD; ops[1] = OP_EQ; ops[2] = OP_LT;
            ops[3] = OP_BEQ; ops[4] = OP_BNE;
            rom[i] = {ops[$urandom_range(0, 4)], 4'($urandom_range(0, 15))};
        end
        for (int i = 0; i < 16; i++) lut[i] = 6'($urandom_range(0, 63));
        step(1, 0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge Clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
